// File: rtl/ram512_arbiter.sv
// ram512_arbiter: round-robin two-port front end for one ram512.
// Build option RAM512_ARBITER_CLEAR_EN zero-fills the RAM after reset.
module ram512_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 9,
  parameter int FIRST_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_write,
  input  logic [ADDR_WIDTH-1:0] p0_req_address,
  input  logic [DATA_WIDTH-1:0] p0_req_data,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_data,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_write,
  input  logic [ADDR_WIDTH-1:0] p1_req_address,
  input  logic [DATA_WIDTH-1:0] p1_req_data,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_data,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_load,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  busy
);

  typedef struct packed {
    logic                  write;
    logic                  port;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  logic                  ptr;
  logic                  grant0;
  logic                  grant1;
  logic                  cmd_valid;
  cmd_t                  cmd;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef RAM512_ARBITER_CLEAR_EN
  logic [ADDR_WIDTH:0] clr_cnt;

  // Clear sweep: one address per cycle until the top bit sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (!clr_cnt[ADDR_WIDTH]) begin
      clr_cnt <= clr_cnt + (ADDR_WIDTH+1)'(1);
    end
  end

  assign busy     = rst_n & ~clr_cnt[ADDR_WIDTH];
  assign clr_addr = clr_cnt[ADDR_WIDTH-1:0];
`else
  assign busy     = 1'b0;
  assign clr_addr = '0;
`endif

  // Round-robin grant; rst_n gating keeps ready low while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !busy) begin
      unique case (1'b1)
        p0_req_valid && p1_req_valid: begin
          grant0 = ~ptr;
          grant1 = ptr;
        end
        p0_req_valid && !p1_req_valid: grant0 = 1'b1;
        !p0_req_valid && p1_req_valid: grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;

  // Pointer always moves to the port that lost or was absent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= (FIRST_PRIORITY != 0);
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end

  // Command register; also tracks the last clear address so the
  // RAM pins hold steady once the sweep ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd       <= '0;
    end else begin
      cmd_valid <= grant0 | grant1;
      if (busy) begin
        cmd.addr <= clr_addr;
        cmd.data <= '0;
      end else if (grant0) begin
        cmd <= '{write: p0_req_write, port: 1'b0,
                 addr: p0_req_address, data: p0_req_data};
      end else if (grant1) begin
        cmd <= '{write: p1_req_write, port: 1'b1,
                 addr: p1_req_address, data: p1_req_data};
      end
    end
  end

  assign mem_address = busy ? clr_addr : cmd.addr;
  assign mem_in      = busy ? '0 : cmd.data;
  assign mem_load    = busy | (cmd_valid & cmd.write);

  // Capture RAM data (pre-write value) for the issuing port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_data  <= '0;
      p1_rsp_data  <= '0;
    end else begin
      p0_rsp_valid <= cmd_valid & ~cmd.port;
      p1_rsp_valid <= cmd_valid & cmd.port;
      if (cmd_valid && !cmd.port) p0_rsp_data <= mem_out;
      if (cmd_valid && cmd.port)  p1_rsp_data <= mem_out;
    end
  end

endmodule

// File: tb/tb_ram512_arbiter.sv
// tb_ram512_arbiter: directed vectors plus reset/clear sequences.
// A behavioural ram512 sits on the mem_* pins.
module tb_ram512_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

`ifdef RAM512_ARBITER_CLEAR_EN
  localparam int          CLR_CYCLES = 512;
  localparam logic [8:0]  IDLE_ADDR  = 9'h1FF;
  localparam logic [15:0] V040       = 16'h0000;
  localparam logic [15:0] V080       = 16'h0000;
`else
  localparam int          CLR_CYCLES = 0;
  localparam logic [8:0]  IDLE_ADDR  = 9'h000;
  localparam logic [15:0] V040       = 16'hAAAA;
  localparam logic [15:0] V080       = 16'h5555;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_write;
  logic [8:0]  p0_req_address;
  logic [15:0] p0_req_data;
  logic        p0_rsp_valid;
  logic [15:0] p0_rsp_data;
  logic        p1_req_valid, p1_req_ready, p1_req_write;
  logic [8:0]  p1_req_address;
  logic [15:0] p1_req_data;
  logic        p1_rsp_valid;
  logic [15:0] p1_rsp_data;
  logic [15:0] mem_in;
  logic [8:0]  mem_address;
  logic        mem_load;
  logic [15:0] mem_out;
  logic        busy;

  logic [15:0] ram [512] = '{default: 16'h0000};

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
  assign mem_out = ram[mem_address];

  ram512_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_write(p0_req_write), .p0_req_address(p0_req_address),
    .p0_req_data(p0_req_data), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_data(p0_rsp_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_write(p1_req_write), .p1_req_address(p1_req_address),
    .p1_req_data(p1_req_data), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_data(p1_rsp_data),
    .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load),
    .mem_out(mem_out), .busy(busy)
  );

  typedef struct {
    logic v0; logic w0; logic [8:0] a0; logic [15:0] d0;
    logic v1; logic w1; logic [8:0] a1; logic [15:0] d1;
    logic r0; logic r1; logic ld; logic [8:0] ea; logic [15:0] ei;
    logic rv0; logic [15:0] rd0; logic rv1; logic [15:0] rd1;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_req_valid = 0; p0_req_write = 0;
    p0_req_address = '0; p0_req_data = '0;
    p1_req_valid = 0; p1_req_write = 0;
    p1_req_address = '0; p1_req_data = '0;
  endtask

  // Release reset and ride out any clear sweep with both ports asking.
  task automatic release_reset();
    int n;
    int bad;
    n = 0;
    bad = 0;
    @(posedge clk); #1;
    rst_n = 1;
    p0_req_valid = 1;
    p1_req_valid = 1;
    while (busy && n < 2000) begin
      bad += int'(p0_req_ready | p1_req_ready);
      @(posedge clk); #1;
      n++;
    end
    p0_req_valid = 0;
    p1_req_valid = 0;
    chk("busy_cycles", n, CLR_CYCLES);
    chk("ready_while_busy", bad, 0);
  endtask

  // Single port-0 access; response checked two edges after acceptance.
  task automatic do_access(input logic w, input logic [8:0] a,
                           input logic [15:0] d, input logic [15:0] exp);
    int n;
    n = 0;
    p0_req_valid = 1; p0_req_write = w;
    p0_req_address = a; p0_req_data = d;
    while (!p0_req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", n < 20, 1);
    @(posedge clk); #1;
    p0_req_valid = 0;
    @(posedge clk); #1;
    chk("acc_rsp_valid", p0_rsp_valid, 1);
    chk("acc_rsp_data", p0_rsp_data, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    tbl[0]  = '{H,H,9'h005,16'h1234, L,L,9'h000,16'h0000,
                H,L,L,IDLE_ADDR,16'h0000, L,16'h0000,L,16'h0000};
    tbl[1]  = '{H,L,9'h005,16'h0000, L,L,9'h000,16'h0000,
                H,L,H,9'h005,16'h1234, L,16'h0000,L,16'h0000};
    tbl[2]  = '{L,L,9'h000,16'h0000, L,L,9'h000,16'h0000,
                L,L,L,9'h005,16'h0000, H,16'h0000,L,16'h0000};
    tbl[3]  = '{H,H,9'h040,16'hAAAA, H,H,9'h080,16'h5555,
                L,H,L,9'h005,16'h0000, H,16'h1234,L,16'h0000};
    tbl[4]  = '{H,H,9'h040,16'hAAAA, H,L,9'h040,16'h0000,
                H,L,H,9'h080,16'h5555, L,16'h1234,L,16'h0000};
    tbl[5]  = '{H,L,9'h080,16'h0000, H,L,9'h040,16'h0000,
                L,H,H,9'h040,16'hAAAA, L,16'h1234,H,16'h0000};
    tbl[6]  = '{H,L,9'h080,16'h0000, H,H,9'h1FF,16'hBEEF,
                H,L,L,9'h040,16'h0000, H,16'h0000,L,16'h0000};
    tbl[7]  = '{H,L,9'h1FF,16'h0000, H,H,9'h1FF,16'hBEEF,
                L,H,L,9'h080,16'h0000, L,16'h0000,H,16'hAAAA};
    tbl[8]  = '{H,L,9'h1FF,16'h0000, L,L,9'h000,16'h0000,
                H,L,H,9'h1FF,16'hBEEF, H,16'h5555,L,16'hAAAA};
    tbl[9]  = '{L,L,9'h000,16'h0000, L,L,9'h000,16'h0000,
                L,L,L,9'h1FF,16'h0000, L,16'h5555,H,16'h0000};
    tbl[10] = '{L,L,9'h000,16'h0000, L,L,9'h000,16'h0000,
                L,L,L,9'h1FF,16'h0000, H,16'hBEEF,L,16'h0000};
    tbl[11] = '{L,L,9'h000,16'h0000, L,L,9'h000,16'h0000,
                L,L,L,9'h1FF,16'h0000, L,16'hBEEF,L,16'h0000};

    // Reset state, with both ports requesting
    rst_n = 0;
    idle_inputs();
    p0_req_valid = 1;
    p1_req_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", p0_req_ready, 0);
    chk("rst_ready1", p1_req_ready, 0);
    chk("rst_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
    chk("rst_rsp_data0", p0_rsp_data, 0);
    chk("rst_rsp_data1", p1_rsp_data, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_load", mem_load, 0);
    chk("rst_busy", busy, 0);
    idle_inputs();
    release_reset();

    // Directed table
    for (int i = 0; i < 12; i++) begin
      p0_req_valid = tbl[i].v0; p0_req_write = tbl[i].w0;
      p0_req_address = tbl[i].a0; p0_req_data = tbl[i].d0;
      p1_req_valid = tbl[i].v1; p1_req_write = tbl[i].w1;
      p1_req_address = tbl[i].a1; p1_req_data = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("v%0d_ready0", i), p0_req_ready, tbl[i].r0);
      chk($sformatf("v%0d_ready1", i), p1_req_ready, tbl[i].r1);
      chk($sformatf("v%0d_mem_load", i), mem_load, tbl[i].ld);
      chk($sformatf("v%0d_mem_addr", i), mem_address, tbl[i].ea);
      if (tbl[i].ld)
        chk($sformatf("v%0d_mem_in", i), mem_in, tbl[i].ei);
      chk($sformatf("v%0d_rsp_v0", i), p0_rsp_valid, tbl[i].rv0);
      chk($sformatf("v%0d_rsp_d0", i), p0_rsp_data, tbl[i].rd0);
      chk($sformatf("v%0d_rsp_v1", i), p1_rsp_valid, tbl[i].rv1);
      chk($sformatf("v%0d_rsp_d1", i), p1_rsp_data, tbl[i].rd1);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Reset during the mem_load cycle of a write
    p0_req_valid = 1; p0_req_write = 1;
    p0_req_address = 9'h010; p0_req_data = 16'h7777;
    @(negedge clk);
    chk("mid_ready0", p0_req_ready, 1);
    @(posedge clk); #1;
    idle_inputs();
    p1_req_valid = 1;
    chk("mid_load_pre", mem_load, 1);
    rst_n = 0;
    #1;
    chk("mid_ready1", p1_req_ready, 0);
    chk("mid_mem_load", mem_load, 0);
    chk("mid_mem_addr", mem_address, 0);
    chk("mid_mem_in", mem_in, 0);
    chk("mid_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
    chk("mid_rsp_data", {p0_rsp_data, p1_rsp_data}, 0);
    chk("mid_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    release_reset();
    pulses = 0;
    repeat (4) begin
      pulses += int'(p0_rsp_valid) + int'(p1_rsp_valid);
      @(posedge clk); #1;
    end
    chk("no_rsp_after_reset", pulses, 0);

    // Sustained contention from reset: p0,p1,p0,p1...
    p0_req_valid = 1; p0_req_address = 9'h040;
    p1_req_valid = 1; p1_req_address = 9'h080;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("alt%0d_ready0", k), p0_req_ready, (k % 2) == 0);
      chk($sformatf("alt%0d_ready1", k), p1_req_ready, (k % 2) == 1);
      if (k >= 2) begin
        chk($sformatf("alt%0d_rsp_v0", k), p0_rsp_valid, (k % 2) == 0);
        chk($sformatf("alt%0d_rsp_v1", k), p1_rsp_valid, (k % 2) == 1);
        if (k % 2 == 0) chk($sformatf("alt%0d_rsp_d0", k), p0_rsp_data, V040);
        else            chk($sformatf("alt%0d_rsp_d1", k), p1_rsp_data, V080);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;

`ifdef RAM512_ARBITER_CLEAR_EN
    // Pre-load nonzero data, reset, confirm the sweep zeroed it
    do_access(1'b1, 9'h000, 16'h1111, 16'h0000);
    do_access(1'b1, 9'h100, 16'h2222, 16'h0000);
    do_access(1'b1, 9'h1FF, 16'h3333, 16'h0000);
    do_access(1'b0, 9'h100, 16'h0000, 16'h2222);
    rst_n = 0;
    @(posedge clk); #1;
    release_reset();
    do_access(1'b0, 9'h000, 16'h0000, 16'h0000);
    do_access(1'b0, 9'h100, 16'h0000, 16'h0000);
    do_access(1'b0, 9'h1FF, 16'h0000, 16'h0000);
`else
    do_access(1'b0, 9'h040, 16'h0000, 16'hAAAA);
    do_access(1'b0, 9'h080, 16'h0000, 16'h5555);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
